// File: rtl/ia_bit_sequencer.sv
`default_nettype none
// ============================================================================
// ia_bit_sequencer : replays an activation vector bit-serially (LSB first) to
// a CIM column array, with aligned accumulator shift/clear and sum strobe.
// Revision 1.0
// ============================================================================
module ia_bit_sequencer #(
    parameter int WORDLEN      = 8,
    parameter int LOG2_WORDLEN = 3,
    parameter int NROWS        = 128,
    parameter int SHIFT_LAG    = 2,
    parameter int PIPE_LAT     = 3
) (
    input  logic                            clock,
    input  logic                            resetn,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NROWS-1:0][WORDLEN-1:0]   in_act,
    output logic [NROWS-1:0]                ia,
    output logic [WORDLEN-1:0]              shift,
    output logic                            acc_clr,
    output logic                            busy,
    output logic                            sum_valid
);

    localparam logic [0:0] STATE_IDLE = 1'b0;
    localparam logic [0:0] STATE_RUN  = 1'b1;
    localparam logic [LOG2_WORDLEN-1:0] LAST_BIT = LOG2_WORDLEN'(WORDLEN - 1);

    logic [0:0]                        state;
    logic [0:0]                        state_next;
    logic [LOG2_WORDLEN-1:0]           bit_idx;
    logic [NROWS-1:0][WORDLEN-1:0]     act_q;
    logic                              accept;
    logic                              last_bit;
    logic [NROWS-1:0]                  plane;
    logic [WORDLEN-1:0]                shift_pre;
    logic                              clr_pre;
    logic                              last_pre;
    logic [WORDLEN-1:0]                shift_dl [SHIFT_LAG];
    logic [SHIFT_LAG-1:0]              clr_dl;
    logic [PIPE_LAT-1:0]               sv_dl;

    assign last_bit = (bit_idx == LAST_BIT);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= STATE_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            STATE_IDLE: if (accept) state_next = STATE_RUN;
            STATE_RUN:  if (last_bit) state_next = accept ? STATE_RUN : STATE_IDLE;
            default:    state_next = STATE_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == STATE_IDLE) || last_bit;
    end

    // Capturing on the last bit lets the next vector follow without a bubble.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            act_q   <= '0;
            bit_idx <= '0;
        end else if (accept) begin
            act_q   <= in_act;
            bit_idx <= '0;
        end else if (state == STATE_RUN) begin
            bit_idx <= bit_idx + LOG2_WORDLEN'(1);
        end
    end

    always_comb begin
        plane = '0;
        for (int r = 0; r < NROWS; r++) begin
            plane[r] = act_q[r][bit_idx];
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ia        <= '0;
            shift_pre <= '0;
            clr_pre   <= 1'b0;
            last_pre  <= 1'b0;
        end else if (state == STATE_RUN) begin
            ia        <= plane;
            shift_pre <= {{(WORDLEN-LOG2_WORDLEN){1'b0}}, bit_idx};
            clr_pre   <= (bit_idx == '0);
            last_pre  <= last_bit;
        end else begin
            ia        <= '0;
            shift_pre <= '0;
            clr_pre   <= 1'b0;
            last_pre  <= 1'b0;
        end
    end

    // Delay lines line the sideband up with the column's internal registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < SHIFT_LAG; i++) begin
                shift_dl[i] <= '0;
            end
            clr_dl <= '0;
            sv_dl  <= '0;
        end else begin
            shift_dl[0] <= shift_pre;
            clr_dl[0]   <= clr_pre;
            for (int i = 1; i < SHIFT_LAG; i++) begin
                shift_dl[i] <= shift_dl[i-1];
                clr_dl[i]   <= clr_dl[i-1];
            end
            sv_dl[0] <= last_pre;
            for (int i = 1; i < PIPE_LAT; i++) begin
                sv_dl[i] <= sv_dl[i-1];
            end
        end
    end

    assign shift     = shift_dl[SHIFT_LAG-1];
    assign acc_clr   = clr_dl[SHIFT_LAG-1];
    assign sum_valid = sv_dl[PIPE_LAT-1];
    assign busy      = (state == STATE_RUN) | clr_pre | last_pre | (|clr_dl) | (|sv_dl);

endmodule
`default_nettype wire

// File: tb/tb_ia_bit_sequencer.sv
`default_nettype none
// ============================================================================
// tb_ia_bit_sequencer : directed checks of ia_bit_sequencer plus a column
// model driven end to end. Revision 1.0
// ============================================================================
module tb_ia_bit_sequencer;

    logic             clock = 1'b0;
    logic             resetn;
    logic             in_valid;
    logic             in_ready;
    logic [3:0][7:0]  in_act;
    logic [3:0]       ia;
    logic [7:0]       shift;
    logic             acc_clr;
    logic             busy;
    logic             sum_valid;

    int total = 0;
    int bad   = 0;

    ia_bit_sequencer #(
        .WORDLEN(8), .LOG2_WORDLEN(3), .NROWS(4), .SHIFT_LAG(2), .PIPE_LAT(3)
    ) dut (
        .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .in_act(in_act), .ia(ia), .shift(shift), .acc_clr(acc_clr),
        .busy(busy), .sum_valid(sum_valid)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Column model: ia register, tree-sum register, then shifted accumulator.
    logic [7:0]  w [4];
    logic [3:0]  ia_q;
    logic [31:0] tree;
    logic [31:0] tree_w;
    logic [31:0] acc;
    logic        e2e_on = 1'b0;
    int          strobes = 0;
    int          exp_q [$];

    always_comb begin
        tree_w = '0;
        for (int r = 0; r < 4; r++) begin
            if (ia_q[r]) tree_w = tree_w + 32'(w[r]);
        end
    end

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ia_q <= '0;
            tree <= '0;
            acc  <= '0;
        end else begin
            ia_q <= ia;
            tree <= tree_w;
            acc  <= acc_clr ? (tree << shift) : (acc + (tree << shift));
        end
    end

    always @(negedge clock) begin
        if (e2e_on && sum_valid) begin
            strobes++;
            chk("e2e pending", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) chk("e2e sum", acc, 32'(exp_q.pop_front()));
        end
    end

    task automatic single_vector(input string name);
        logic [3:0] e_ia;
        in_act   = {8'h01, 8'h80, 8'hFF, 8'h00};
        in_valid = 1'b1;
        chk({name, " ready pre"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        in_act   = 32'hDEADBEEF;
        chk({name, " busy t0"}, busy, 1);
        chk({name, " ready t0"}, in_ready, 0);
        chk({name, " ia t0"}, ia, 0);
        for (int k = 1; k <= 12; k++) begin
            tick();
            e_ia = (k == 1) ? 4'b1010 : (k <= 7) ? 4'b0010 : (k == 8) ? 4'b0110 : 4'b0000;
            chk($sformatf("%s ia k%0d", name, k), ia, e_ia);
            chk($sformatf("%s shift k%0d", name, k), shift, (k >= 3 && k <= 10) ? k - 3 : 0);
            chk($sformatf("%s clr k%0d", name, k), acc_clr, k == 3);
            chk($sformatf("%s sv k%0d", name, k), sum_valid, k == 11);
            chk($sformatf("%s busy k%0d", name, k), busy, k <= 11);
            chk($sformatf("%s ready k%0d", name, k), in_ready, k >= 7);
        end
    endtask

    task automatic send(input logic [3:0][7:0] act);
        int n = 0;
        int e = 0;
        in_valid = 1'b1;
        in_act   = act;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        chk("e2e accept", in_ready, 1);
        for (int r = 0; r < 4; r++) e += int'(act[r]) * int'(w[r]);
        exp_q.push_back(e);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] e_ia;
        logic [3:0][7:0] act;
        int gap;
        for (int r = 0; r < 4; r++) w[r] = '0;

        // Reset held with in_valid asserted
        resetn   = 1'b0;
        in_valid = 1'b1;
        in_act   = 32'hFFFF_FFFF;
        tick();
        tick();
        chk("rst ready", in_ready, 1);
        chk("rst ia", ia, 0);
        chk("rst shift", shift, 0);
        chk("rst clr", acc_clr, 0);
        chk("rst sv", sum_valid, 0);
        chk("rst busy", busy, 0);
        in_valid = 1'b0;
        resetn   = 1'b1;
        tick();
        chk("post rst busy", busy, 0);
        chk("post rst ia", ia, 0);

        single_vector("single");
        tick();

        // Back-to-back: A then B with in_valid held high
        in_act   = {8'hF0, 8'h0F, 8'h00, 8'h00};
        in_valid = 1'b1;
        tick();
        in_act = {8'h00, 8'h00, 8'h55, 8'hAA};
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 8) in_valid = 1'b0;
            if (k <= 4)       e_ia = 4'b0100;
            else if (k <= 8)  e_ia = 4'b1000;
            else if (k <= 16) e_ia = (k % 2 == 1) ? 4'b0010 : 4'b0001;
            else              e_ia = 4'b0000;
            chk($sformatf("b2b ia k%0d", k), ia, e_ia);
            chk($sformatf("b2b shift k%0d", k), shift, (k >= 3 && k <= 18) ? (k - 3) % 8 : 0);
            chk($sformatf("b2b clr k%0d", k), acc_clr, k == 3 || k == 11);
            chk($sformatf("b2b sv k%0d", k), sum_valid, k == 11 || k == 19);
            chk($sformatf("b2b busy k%0d", k), busy, k <= 19);
            chk($sformatf("b2b ready k%0d", k), in_ready, k == 7 || k >= 15);
        end

        // Stall gap: C, idle, then D accepted at edge t0+11
        in_act   = {8'h00, 8'h00, 8'h00, 8'h01};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= 23; k++) begin
            tick();
            if (k == 10) begin
                in_valid = 1'b1;
                in_act   = {8'h80, 8'h00, 8'h00, 8'h00};
            end
            if (k == 11) in_valid = 1'b0;
            e_ia = (k == 1) ? 4'b0001 : (k == 19) ? 4'b1000 : 4'b0000;
            chk($sformatf("gap ia k%0d", k), ia, e_ia);
            chk($sformatf("gap shift k%0d", k), shift,
                (k >= 3 && k <= 10) ? k - 3 : (k >= 14 && k <= 21) ? k - 14 : 0);
            chk($sformatf("gap clr k%0d", k), acc_clr, k == 3 || k == 14);
            chk($sformatf("gap sv k%0d", k), sum_valid, k == 11 || k == 22);
            chk($sformatf("gap busy k%0d", k), busy, k <= 22);
            chk($sformatf("gap ready k%0d", k), in_ready, (k >= 7 && k <= 10) || k >= 18);
        end

        // Reset at bit 4 of a vector
        in_act   = 32'hFFFF_FFFF;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) tick();
        chk("abort shift before", shift, 1);
        resetn = 1'b0;
        #1;
        chk("abort ia", ia, 0);
        chk("abort shift", shift, 0);
        chk("abort clr", acc_clr, 0);
        chk("abort busy", busy, 0);
        chk("abort ready", in_ready, 1);
        tick();
        resetn = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk($sformatf("abort sv k%0d", k), sum_valid, 0);
            chk($sformatf("abort clr k%0d", k), acc_clr, 0);
            chk($sformatf("abort ia k%0d", k), ia, 0);
        end
        single_vector("again");
        tick();

        // End to end through the column model
        for (int r = 0; r < 4; r++) w[r] = 8'($urandom_range(0, 255));
        e2e_on = 1'b1;
        for (int v = 0; v < 1000; v++) begin
            for (int r = 0; r < 4; r++) act[r] = 8'($urandom_range(0, 255));
            if (v % 10 == 0) act = (v % 20 == 0) ? 32'hFFFF_FFFF : 32'h0;
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            repeat (gap) tick();
            send(act);
        end
        for (int n = 0; n < 30 && exp_q.size() > 0; n++) tick();
        chk("e2e drained", exp_q.size(), 0);
        chk("e2e strobes", strobes, 1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
